// File: rtl/ones_idx_serializer.sv
// Walks a latched bitmap and emits the index of each set bit, lowest index first,
// one per out_valid/out_ready handshake, while reporting how many indices are left.
module ones_idx_serializer #(
  parameter  int LOG_VEC_SIZE = 3,
  localparam int VEC_SIZE     = 1 << LOG_VEC_SIZE
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:VEC_SIZE-1]     in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LOG_VEC_SIZE-1:0] out_idx,
  output logic                    out_last,
  output logic [LOG_VEC_SIZE:0]   remaining,
  output logic                    zero_drop
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                state, state_next;
  logic [0:VEC_SIZE-1]   pending, pending_next;
  logic                  zero_drop_next;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      pending   <= '0;
      zero_drop <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      zero_drop <= zero_drop_next;
    end
  end

  // Priority encode the lowest set index and count the pending ones.
  always_comb begin
    out_idx   = '0;
    remaining = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (pending[i]) out_idx = LOG_VEC_SIZE'(i);
    end
    for (int i = 0; i < VEC_SIZE; i++) begin
      remaining = remaining + (LOG_VEC_SIZE + 1)'(pending[i]);
    end
  end

  assign out_last  = (remaining == (LOG_VEC_SIZE + 1)'(1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);

  always_comb begin
    state_next     = state;
    pending_next   = pending;
    zero_drop_next = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec == '0) begin
            zero_drop_next = 1'b1;
          end else begin
            pending_next = in_vec;
            state_next   = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_next[out_idx] = 1'b0;
          if (out_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ones_idx_serializer.sv
// Directed bench for ones_idx_serializer: hand-computed index streams per bitmap.
module tb_ones_idx_serializer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic [3:0] remaining;
  logic       zero_drop;

  int checks = 0;
  int errors = 0;

  ones_idx_serializer #(.LOG_VEC_SIZE(3)) dut (
    .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .remaining(remaining),
    .zero_drop(zero_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL reset_remaining got %0d want 0", remaining); end
    checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL reset_zero_drop got %b want 0", zero_drop); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    resetN = 1'b1;
    step();
  endtask

  task automatic test_zero_vec();
    in_valid = 1'b1; in_vec = 8'b0000_0000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (zero_drop !== 1'b1) begin errors++; $display("FAIL zero_drop_pulse got %b want 1", zero_drop); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready got %b want 1", in_ready); end
    step();
    checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL zero_drop_clear got %b want 0", zero_drop); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid2 got %b want 0", out_valid); end
  endtask

  task automatic test_sparse();
    logic [2:0] exp_idx [4] = '{3'd0, 3'd3, 3'd4, 3'd5};
    in_valid = 1'b1; in_vec = 8'b1001_1100; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_vec = 8'b1111_1111;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid beat %0d got %b want 1", k, out_valid); end
      checks++; if (out_idx !== exp_idx[k]) begin errors++; $display("FAIL sparse_idx beat %0d got %0d want %0d", k, out_idx, exp_idx[k]); end
      checks++; if (remaining !== 4'(4 - k)) begin errors++; $display("FAIL sparse_remaining beat %0d got %0d want %0d", k, remaining, 4 - k); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL sparse_last beat %0d got %b want %b", k, out_last, (k == 3)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sparse_in_ready beat %0d got %b want 0", k, in_ready); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_done_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sparse_done_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_all_ones();
    in_valid = 1'b1; in_vec = 8'b1111_1111; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_idx !== 3'(k)) begin errors++; $display("FAIL ones_idx beat %0d got %0d want %0d", k, out_idx, k); end
      checks++; if (remaining !== 4'(8 - k)) begin errors++; $display("FAIL ones_remaining beat %0d got %0d want %0d", k, remaining, 8 - k); end
      checks++; if (out_last !== (k == 7)) begin errors++; $display("FAIL ones_last beat %0d got %b want %b", k, out_last, (k == 7)); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_done_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_vec = 8'b0100_0000; out_ready = 1'b0;
    step();
    in_vec = 8'b1111_1111;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b want 1", k, out_valid); end
      checks++; if (out_idx !== 3'd1) begin errors++; $display("FAIL bp_idx cycle %0d got %0d want 1", k, out_idx); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL bp_last cycle %0d got %b want 1", k, out_last); end
      checks++; if (remaining !== 4'd1) begin errors++; $display("FAIL bp_remaining cycle %0d got %0d want 1", k, remaining); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
      if (k < 4) step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_done_in_ready got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_vec got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_emit();
    in_valid = 1'b1; in_vec = 8'b1011_1010; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL rst_beat0_idx got %0d want 0", out_idx); end
    checks++; if (remaining !== 4'd5) begin errors++; $display("FAIL rst_beat0_remaining got %0d want 5", remaining); end
    step();
    checks++; if (out_idx !== 3'd2) begin errors++; $display("FAIL rst_beat1_idx got %0d want 2", out_idx); end
    checks++; if (remaining !== 4'd4) begin errors++; $display("FAIL rst_beat1_remaining got %0d want 4", remaining); end
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (remaining !== 4'd0) begin errors++; $display("FAIL rst_mid_remaining got %0d want 0", remaining); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    in_valid = 1'b1; in_vec = 8'b0000_0001;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
    checks++; if (out_idx !== 3'd7) begin errors++; $display("FAIL post_rst_idx got %0d want 7", out_idx); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL post_rst_last got %b want 1", out_last); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_done got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_vec();
    test_sparse();
    test_all_ones();
    test_backpressure();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
